// File: rtl/tsn_ibm_rx.sv
// Input buffer manager receive front end: allocates a buffer ID per packet,
// writes beats into the packet buffer RAM and emits a descriptor on good tails.
module tsn_ibm_rx #(
  parameter int NUM_BUF = 16,
  parameter int LINE_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [133:0]        in_ibm_data,
  input  logic                in_ibm_data_wr,
  input  logic                in_ibm_valid,
  input  logic                in_ibm_valid_wr,
  input  logic [23:0]         in_ibm_tsn_md,
  input  logic                in_ibm_tsn_md_wr,
  input  logic [4:0]          in_ibm_id_free,
  input  logic                in_ibm_id_free_wr,
  output logic [4:0]          bufm_ID_count,
  output logic                out_ibm_buf_wr,
  output logic [5+LINE_W-1:0] out_ibm_buf_addr,
  output logic [133:0]        out_ibm_buf_data,
  output logic [31:0]         out_ibm_desc,
  output logic                out_ibm_desc_wr,
  output logic [63:0]         ibm_pkt_cnt,
  output logic [31:0]         ibm_drop_cnt,
  output logic [1:0]          dbg_state
);

  // Handshake: every input is a one-cycle strobe (no backpressure); a beat is
  // taken on any cycle with in_ibm_data_wr=1, outputs are one-cycle strobes.
  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, DROP = 2'd2} state_t;

  localparam logic [LINE_W-1:0] LINE_ONE  = 1;
  localparam logic [LINE_W-1:0] LINE_LAST = '1;

  state_t              state, state_nx;
  logic [NUM_BUF-1:0]  free_map;
  logic [4:0]          cur_id;
  logic [LINE_W-1:0]   line;
  logic [23:0]         md;

  logic                is_head, is_tail, good_tail;
  logic [LINE_W-1:0]   next_line, wr_line;
  logic [4:0]          alloc_id, wr_id;
  logic                any_free, alloc, ret, wr_en, desc_fire, drop, ext_ok;
  logic [31:0]         map32, map_nx32;
  logic [11:0]         len_full;

  assign is_head   = in_ibm_data_wr && (in_ibm_data[133:132] == 2'b01);
  assign is_tail   = in_ibm_data_wr && (in_ibm_data[133:132] == 2'b10);
  assign good_tail = in_ibm_valid && in_ibm_valid_wr;
  assign next_line = line + LINE_ONE;
  assign dbg_state = state;

  // Lowest-numbered free ID: descending scan so the last hit wins.
  always_comb begin
    alloc_id = 5'd0;
    any_free = 1'b0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (free_map[i]) begin
        alloc_id = 5'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    alloc     = 1'b0;
    ret       = 1'b0;
    wr_en     = 1'b0;
    wr_line   = '0;
    desc_fire = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (is_head) begin
          if (any_free) begin
            alloc    = 1'b1;
            wr_en    = 1'b1;
            state_nx = WR;
          end else begin
            drop     = 1'b1;
            state_nx = DROP;
          end
        end
      end
      WR: begin
        if (is_tail) begin
          wr_en    = 1'b1;
          wr_line  = next_line;
          state_nx = IDLE;
          if (good_tail) begin
            desc_fire = 1'b1;
          end else begin
            ret  = 1'b1;
            drop = 1'b1;
          end
        end else if (in_ibm_data_wr) begin
          // The last line is reserved for a tail; anything else is oversize.
          if (next_line == LINE_LAST) begin
            ret      = 1'b1;
            drop     = 1'b1;
            state_nx = DROP;
          end else begin
            wr_en   = 1'b1;
            wr_line = next_line;
          end
        end
      end
      DROP: begin
        if (is_tail) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // External free is ignored for out-of-range, already-free, or the ID being
  // returned internally this cycle; the allocated ID is still marked free here.
  always_comb begin
    map32    = 32'(free_map);
    ext_ok   = in_ibm_id_free_wr && (32'(in_ibm_id_free) < 32'(NUM_BUF)) &&
               !map32[in_ibm_id_free] && !(ret && (in_ibm_id_free == cur_id));
    map_nx32 = map32;
    if (alloc)  map_nx32[alloc_id] = 1'b0;
    if (ret)    map_nx32[cur_id] = 1'b1;
    if (ext_ok) map_nx32[in_ibm_id_free] = 1'b1;
  end

  assign wr_id    = (state == IDLE) ? alloc_id : cur_id;
  assign len_full = (({{(12-LINE_W){1'b0}}, wr_line} + 12'd1) << 4) - {8'd0, in_ibm_data[131:128]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      free_map         <= '1;
      bufm_ID_count    <= 5'(NUM_BUF);
      cur_id           <= '0;
      line             <= '0;
      md               <= '0;
      out_ibm_buf_wr   <= 1'b0;
      out_ibm_buf_addr <= '0;
      out_ibm_buf_data <= '0;
      out_ibm_desc     <= '0;
      out_ibm_desc_wr  <= 1'b0;
      ibm_pkt_cnt      <= '0;
      ibm_drop_cnt     <= '0;
    end else begin
      state         <= state_nx;
      free_map      <= map_nx32[NUM_BUF-1:0];
      bufm_ID_count <= bufm_ID_count + 5'(ret) + 5'(ext_ok) - 5'(alloc);
      if (alloc) begin
        cur_id <= alloc_id;
        md     <= in_ibm_tsn_md_wr ? in_ibm_tsn_md : 24'd0;
      end
      if (wr_en) begin
        line             <= wr_line;
        out_ibm_buf_addr <= {wr_id, wr_line};
        out_ibm_buf_data <= in_ibm_data;
      end
      out_ibm_buf_wr  <= wr_en;
      out_ibm_desc_wr <= desc_fire;
      if (desc_fire) begin
        out_ibm_desc <= {md[23:21], md[20:9], md[8], cur_id, len_full[10:0]};
        ibm_pkt_cnt  <= ibm_pkt_cnt + 64'd1;
      end
      if (drop) ibm_drop_cnt <= ibm_drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_tsn_ibm_rx.sv
// Directed bench for tsn_ibm_rx: allocation, exhaustion, frees, drops,
// oversize packets, back-to-back packets and mid-packet reset.
module tb_tsn_ibm_rx;

  logic         clk, rst_n;
  logic [133:0] in_ibm_data;
  logic         in_ibm_data_wr, in_ibm_valid, in_ibm_valid_wr;
  logic [23:0]  in_ibm_tsn_md;
  logic         in_ibm_tsn_md_wr;
  logic [4:0]   in_ibm_id_free;
  logic         in_ibm_id_free_wr;
  logic [4:0]   bufm_ID_count;
  logic         out_ibm_buf_wr;
  logic [11:0]  out_ibm_buf_addr;
  logic [133:0] out_ibm_buf_data;
  logic [31:0]  out_ibm_desc;
  logic         out_ibm_desc_wr;
  logic [63:0]  ibm_pkt_cnt;
  logic [31:0]  ibm_drop_cnt;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] obs_addr_q[$];
  logic [31:0] obs_desc_q[$];
  logic [11:0] exp_q[$];
  logic [31:0] exp_desc_q[$];

  tsn_ibm_rx #(.NUM_BUF(16), .LINE_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_ibm_data(in_ibm_data), .in_ibm_data_wr(in_ibm_data_wr),
    .in_ibm_valid(in_ibm_valid), .in_ibm_valid_wr(in_ibm_valid_wr),
    .in_ibm_tsn_md(in_ibm_tsn_md), .in_ibm_tsn_md_wr(in_ibm_tsn_md_wr),
    .in_ibm_id_free(in_ibm_id_free), .in_ibm_id_free_wr(in_ibm_id_free_wr),
    .bufm_ID_count(bufm_ID_count), .out_ibm_buf_wr(out_ibm_buf_wr),
    .out_ibm_buf_addr(out_ibm_buf_addr), .out_ibm_buf_data(out_ibm_buf_data),
    .out_ibm_desc(out_ibm_desc), .out_ibm_desc_wr(out_ibm_desc_wr),
    .ibm_pkt_cnt(ibm_pkt_cnt), .ibm_drop_cnt(ibm_drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor samples registered strobes on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_ibm_buf_wr) obs_addr_q.push_back(out_ibm_buf_addr);
      if (out_ibm_desc_wr) obs_desc_q.push_back(out_ibm_desc);
    end
  end

  // drivers: inputs change on the falling edge, task returns 1 time unit after the rising edge
  task automatic cyc(input logic dwr, input logic [1:0] typ, input logic [3:0] inv,
                     input logic vld, input logic [23:0] md, input logic mdwr,
                     input logic [4:0] fid, input logic fwr);
    @(negedge clk);
    in_ibm_data_wr    = dwr;
    in_ibm_data       = {typ, inv, $urandom(), $urandom(), $urandom(), $urandom()};
    in_ibm_valid      = vld;
    in_ibm_valid_wr   = dwr && (typ == 2'b10);
    in_ibm_tsn_md     = md;
    in_ibm_tsn_md_wr  = mdwr;
    in_ibm_id_free    = fid;
    in_ibm_id_free_wr = fwr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'b00, 4'd0, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic free_id(input logic [4:0] id);
    cyc(1'b0, 2'b00, 4'd0, 1'b0, 24'd0, 1'b0, id, 1'b1);
  endtask

  task automatic send_pkt(input int n, input logic [3:0] inv, input logic vld, input logic [23:0] md);
    cyc(1'b1, 2'b01, 4'd0, 1'b0, md, 1'b1, 5'd0, 1'b0);
    for (int i = 1; i < n - 1; i++) cyc(1'b1, 2'b11, 4'd0, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 2'b10, inv, vld, 24'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_desc_q.delete();
    exp_q.delete();
    exp_desc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_ibm_data = '0; in_ibm_data_wr = 0; in_ibm_valid = 0; in_ibm_valid_wr = 0;
    in_ibm_tsn_md = '0; in_ibm_tsn_md_wr = 0; in_ibm_id_free = '0; in_ibm_id_free_wr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bufm_ID_count !== 5'd16) begin errors++; $display("FAIL reset_count got %0d want 16", bufm_ID_count); end
    checks++; if ({out_ibm_buf_wr, out_ibm_buf_addr, out_ibm_buf_data, out_ibm_desc, out_ibm_desc_wr} !== '0) begin errors++; $display("FAIL reset_outputs got nonzero want 0"); end
    checks++; if (ibm_pkt_cnt !== 64'd0 || ibm_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", ibm_pkt_cnt, ibm_drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_obs();
    cyc(1'b1, 2'b01, 4'd0, 1'b0, 24'h2ABC00, 1'b1, 5'd0, 1'b0);
    checks++; if (bufm_ID_count !== 5'd15) begin errors++; $display("FAIL basic_count got %0d want 15", bufm_ID_count); end
    checks++; if (out_ibm_buf_wr !== 1'b1 || out_ibm_buf_data !== in_ibm_data) begin errors++; $display("FAIL basic_head_write got wr=%b data=%h want wr=1 data=%h", out_ibm_buf_wr, out_ibm_buf_data, in_ibm_data); end
    cyc(1'b1, 2'b11, 4'd0, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 2'b11, 4'd0, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 2'b10, 4'd4, 1'b1, 24'd0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_ibm_desc_wr !== 1'b1) begin errors++; $display("FAIL basic_desc_latency got %b want 1", out_ibm_desc_wr); end
    idle(2);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'd0, 7'(i)});
    checks++; if (obs_addr_q.size() != 4) begin errors++; $display("FAIL basic_nwrites got %0d want 4", obs_addr_q.size()); end
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
      checks++; if (obs_addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, obs_addr_q[i], exp_q[i]); end
    end
    checks++; if (obs_desc_q.size() != 1 || obs_desc_q[0] !== {3'd1, 12'h55E, 1'b0, 5'd0, 11'd60}) begin errors++; $display("FAIL basic_desc got n=%0d %h want %h", obs_desc_q.size(), out_ibm_desc, {3'd1, 12'h55E, 1'b0, 5'd0, 11'd60}); end
    checks++; if (ibm_pkt_cnt !== 64'd1) begin errors++; $display("FAIL basic_pkt_cnt got %0d want 1", ibm_pkt_cnt); end
  endtask

  task automatic test_exhaust();
    free_id(5'd0);
    checks++; if (bufm_ID_count !== 5'd16) begin errors++; $display("FAIL exh_free0 got %0d want 16", bufm_ID_count); end
    clear_obs();
    for (int i = 0; i < 16; i++) send_pkt(2, 4'd0, 1'b1, 24'd0);
    idle(2);
    checks++; if (obs_desc_q.size() != 16) begin errors++; $display("FAIL exh_ndesc got %0d want 16", obs_desc_q.size()); end
    for (int i = 0; i < 16 && i < obs_desc_q.size(); i++) begin
      checks++; if (obs_desc_q[i] !== {16'd0, 5'(i), 11'd32}) begin errors++; $display("FAIL exh_desc%0d got %h want %h", i, obs_desc_q[i], {16'd0, 5'(i), 11'd32}); end
    end
    checks++; if (bufm_ID_count !== 5'd0) begin errors++; $display("FAIL exh_count got %0d want 0", bufm_ID_count); end
    clear_obs();
    send_pkt(3, 4'd0, 1'b1, 24'd0);
    idle(2);
    checks++; if (obs_addr_q.size() != 0 || obs_desc_q.size() != 0) begin errors++; $display("FAIL exh_drop_out got w=%0d d=%0d want 0/0", obs_addr_q.size(), obs_desc_q.size()); end
    checks++; if (ibm_drop_cnt !== 32'd1 || bufm_ID_count !== 5'd0) begin errors++; $display("FAIL exh_drop got drop=%0d cnt=%0d want 1/0", ibm_drop_cnt, bufm_ID_count); end
    free_id(5'd5);
    checks++; if (bufm_ID_count !== 5'd1) begin errors++; $display("FAIL exh_free5 got %0d want 1", bufm_ID_count); end
    clear_obs();
    send_pkt(2, 4'd0, 1'b1, 24'd0);
    idle(2);
    checks++; if (obs_desc_q.size() != 1 || obs_desc_q[0] !== {16'd0, 5'd5, 11'd32}) begin errors++; $display("FAIL exh_id5 got n=%0d %h want %h", obs_desc_q.size(), out_ibm_desc, {16'd0, 5'd5, 11'd32}); end
    checks++; if (bufm_ID_count !== 5'd0) begin errors++; $display("FAIL exh_count2 got %0d want 0", bufm_ID_count); end
  endtask

  task automatic test_same_cycle();
    for (int i = 4; i < 16; i++) free_id(5'(i));
    free_id(5'd20);
    free_id(5'd6);
    checks++; if (bufm_ID_count !== 5'd12) begin errors++; $display("FAIL sc_ignore got %0d want 12", bufm_ID_count); end
    clear_obs();
    cyc(1'b1, 2'b01, 4'd0, 1'b0, 24'd0, 1'b1, 5'd3, 1'b1);
    checks++; if (bufm_ID_count !== 5'd12) begin errors++; $display("FAIL sc_count got %0d want 12", bufm_ID_count); end
    checks++; if (out_ibm_buf_addr !== {5'd4, 7'd0}) begin errors++; $display("FAIL sc_addr got %h want %h", out_ibm_buf_addr, {5'd4, 7'd0}); end
    cyc(1'b1, 2'b10, 4'd0, 1'b1, 24'd0, 1'b0, 5'd0, 1'b0);
    idle(2);
    checks++; if (obs_desc_q.size() != 1 || obs_desc_q[0] !== {16'd0, 5'd4, 11'd32}) begin errors++; $display("FAIL sc_desc got n=%0d %h want %h", obs_desc_q.size(), out_ibm_desc, {16'd0, 5'd4, 11'd32}); end
  endtask

  task automatic test_bad_tail();
    clear_obs();
    cyc(1'b1, 2'b01, 4'd0, 1'b0, 24'd0, 1'b1, 5'd0, 1'b0);
    checks++; if (bufm_ID_count !== 5'd11 || out_ibm_buf_addr !== {5'd3, 7'd0}) begin errors++; $display("FAIL bad_head got cnt=%0d addr=%h want 11/%h", bufm_ID_count, out_ibm_buf_addr, {5'd3, 7'd0}); end
    cyc(1'b1, 2'b10, 4'd0, 1'b0, 24'd0, 1'b0, 5'd4, 1'b1);
    checks++; if (bufm_ID_count !== 5'd13) begin errors++; $display("FAIL bad_count got %0d want 13", bufm_ID_count); end
    checks++; if (ibm_drop_cnt !== 32'd2) begin errors++; $display("FAIL bad_drop got %0d want 2", ibm_drop_cnt); end
    idle(2);
    checks++; if (obs_desc_q.size() != 0) begin errors++; $display("FAIL bad_desc got %0d want 0", obs_desc_q.size()); end
  endtask

  task automatic test_oversize();
    clear_obs();
    send_pkt(130, 4'd0, 1'b1, 24'd0);
    idle(2);
    checks++; if (obs_addr_q.size() != 127) begin errors++; $display("FAIL ovr_nwrites got %0d want 127", obs_addr_q.size()); end
    checks++; if (obs_addr_q.size() != 0 && obs_addr_q[obs_addr_q.size()-1] !== {5'd3, 7'd126}) begin errors++; $display("FAIL ovr_last_addr got %h want %h", obs_addr_q[obs_addr_q.size()-1], {5'd3, 7'd126}); end
    checks++; if (obs_desc_q.size() != 0 || ibm_drop_cnt !== 32'd3 || bufm_ID_count !== 5'd13) begin errors++; $display("FAIL ovr_drop got d=%0d drop=%0d cnt=%0d want 0/3/13", obs_desc_q.size(), ibm_drop_cnt, bufm_ID_count); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL ovr_state got %0d want 0", dbg_state); end
    clear_obs();
    send_pkt(3, 4'd8, 1'b1, 24'hE00100);
    idle(2);
    checks++; if (obs_desc_q.size() != 1 || obs_desc_q[0] !== {3'd7, 12'h000, 1'b1, 5'd3, 11'd40}) begin errors++; $display("FAIL ovr_next got n=%0d %h want %h", obs_desc_q.size(), out_ibm_desc, {3'd7, 12'h000, 1'b1, 5'd3, 11'd40}); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_pkt(2, 4'd15, 1'b1, 24'h5FFE00);
    send_pkt(2, 4'd0, 1'b1, 24'h012300);
    idle(2);
    exp_q = '{{5'd4, 7'd0}, {5'd4, 7'd1}, {5'd5, 7'd0}, {5'd5, 7'd1}};
    exp_desc_q = '{{3'd2, 12'hFFF, 1'b0, 5'd4, 11'd17}, {3'd0, 12'h091, 1'b1, 5'd5, 11'd32}};
    checks++; if (obs_addr_q.size() != 4 || obs_desc_q.size() != 2) begin errors++; $display("FAIL b2b_counts got w=%0d d=%0d want 4/2", obs_addr_q.size(), obs_desc_q.size()); end
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
      checks++; if (obs_addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_addr%0d got %h want %h", i, obs_addr_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 2 && i < obs_desc_q.size(); i++) begin
      checks++; if (obs_desc_q[i] !== exp_desc_q[i]) begin errors++; $display("FAIL b2b_desc%0d got %h want %h", i, obs_desc_q[i], exp_desc_q[i]); end
    end
    checks++; if (ibm_pkt_cnt !== 64'd22) begin errors++; $display("FAIL b2b_pkt_cnt got %0d want 22", ibm_pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 2'b01, 4'd0, 1'b0, 24'd0, 1'b1, 5'd0, 1'b0);
    cyc(1'b1, 2'b11, 4'd0, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    in_ibm_data_wr = 0; in_ibm_valid_wr = 0; in_ibm_tsn_md_wr = 0; in_ibm_id_free_wr = 0;
    #1;
    checks++; if (bufm_ID_count !== 5'd16) begin errors++; $display("FAIL rmid_count got %0d want 16", bufm_ID_count); end
    checks++; if ({out_ibm_buf_wr, out_ibm_buf_addr, out_ibm_desc_wr, out_ibm_desc, ibm_pkt_cnt, ibm_drop_cnt} !== '0) begin errors++; $display("FAIL rmid_outputs got nonzero want 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    send_pkt(2, 4'd0, 1'b1, 24'd0);
    idle(2);
    checks++; if (obs_desc_q.size() != 1 || obs_desc_q[0] !== {16'd0, 5'd0, 11'd32}) begin errors++; $display("FAIL rmid_desc got n=%0d %h want %h", obs_desc_q.size(), out_ibm_desc, {16'd0, 5'd0, 11'd32}); end
    checks++; if (ibm_pkt_cnt !== 64'd1) begin errors++; $display("FAIL rmid_pkt_cnt got %0d want 1", ibm_pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exhaust();
    test_same_cycle();
    test_bad_tail();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
